// File: rtl/keypad_entry_receiver_if.sv
// Digit/strobe, control and preset-handshake signals between the keypad
// encoder, the entry receiver and the timer preset path.
interface keypad_entry_receiver_if;
  logic [3:0] D;
  logic       loadn;
  logic       mag_on;
  logic       commit;
  logic       cancel;
  logic       preset_ack;
  logic [3:0] entry_mins;
  logic [3:0] entry_sec_tens;
  logic [3:0] entry_sec_ones;
  logic [1:0] digit_count;
  logic       preset_req;
  logic       entry_err;

  modport master (
    output D, loadn, mag_on, commit, cancel, preset_ack,
    input  entry_mins, entry_sec_tens, entry_sec_ones, digit_count, preset_req, entry_err
  );

  modport slave (
    input  D, loadn, mag_on, commit, cancel, preset_ack,
    output entry_mins, entry_sec_tens, entry_sec_ones, digit_count, preset_req, entry_err
  );
endinterface

// File: rtl/keypad_entry_receiver.sv
// Keypad entry receiver: synchronizes encoder strobes, shifts BCD digits into a
// mins:sec_tens:sec_ones entry and presets the timer via req/ack.
// Optional macro AUTO_NORMALIZE_EN: commit normalizes sec_tens overflow into minutes.
module keypad_entry_receiver #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [3:0] MAX_SEC_TENS = 4'd5
) (
  input logic                   clock,
  input logic                   clearn,
  keypad_entry_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_REQ   = 2'd2
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] loadn_sync_r;
  logic [3:0]             d_sync_r [SYNC_STAGES];
  logic                   loadn_prev_r;
  logic [3:0]             mins_r;
  logic [3:0]             tens_r;
  logic [3:0]             ones_r;
  logic [1:0]             count_r;
  logic                   preset_req_r;
  logic                   entry_err_r;

  logic       strobe_s;
  logic [3:0] d_s;
  logic       open_s;
  logic       dig_evt_s;
  logic       dig_ok_s;
  logic       dig_err_s;
  logic       commit_s;
  logic       has_entry_s;
  logic       commit_ok_s;
  logic       commit_err_s;
  logic       err_s;
  logic [3:0] sh_mins_s;
  logic [3:0] sh_tens_s;
  logic [3:0] sh_ones_s;
  logic [1:0] sh_count_s;
  logic [3:0] fin_mins_s;
  logic [3:0] fin_tens_s;
  logic [3:0] fin_ones_s;

  // Synchronizer chains for the asynchronous strobe and its digit.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      loadn_sync_r <= '1;
      loadn_prev_r <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        d_sync_r[i] <= 4'd0;
      end
    end else begin
      loadn_sync_r <= {loadn_sync_r[SYNC_STAGES-2:0], bus.loadn};
      loadn_prev_r <= loadn_sync_r[SYNC_STAGES-1];
      d_sync_r[0]  <= bus.D;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        d_sync_r[i] <= d_sync_r[i-1];
      end
    end
  end

  assign strobe_s = loadn_prev_r & ~loadn_sync_r[SYNC_STAGES-1];
  assign d_s      = d_sync_r[SYNC_STAGES-1];

  // Next-entry decode: shift first, then judge commit on the shifted value.
  always_comb begin
    open_s      = (state_r == ST_IDLE) || (state_r == ST_ENTRY);
    dig_evt_s   = strobe_s && open_s && !bus.mag_on && !bus.cancel;
    dig_ok_s    = dig_evt_s && (d_s <= 4'd9) && (count_r != 2'd3);
    dig_err_s   = dig_evt_s && !dig_ok_s;
    if (dig_ok_s) begin
      sh_mins_s  = tens_r;
      sh_tens_s  = ones_r;
      sh_ones_s  = d_s;
      sh_count_s = count_r + 2'd1;
    end else begin
      sh_mins_s  = mins_r;
      sh_tens_s  = tens_r;
      sh_ones_s  = ones_r;
      sh_count_s = count_r;
    end
    commit_s    = bus.commit && open_s && !bus.cancel;
    has_entry_s = (state_r == ST_ENTRY) || dig_ok_s;
    fin_mins_s  = sh_mins_s;
    fin_tens_s  = sh_tens_s;
    fin_ones_s  = sh_ones_s;
    if (commit_s && has_entry_s) begin
      if (sh_tens_s <= MAX_SEC_TENS) begin
        commit_ok_s = 1'b1;
      end else begin
`ifdef AUTO_NORMALIZE_EN
        // Taking 60 s off S only touches the tens digit; mins carries one.
        if ((sh_tens_s >= 4'd6) && (sh_mins_s < 4'd9)) begin
          commit_ok_s = 1'b1;
          fin_mins_s  = sh_mins_s + 4'd1;
          fin_tens_s  = sh_tens_s - 4'd6;
        end else begin
          commit_ok_s = 1'b0;
        end
`else
        commit_ok_s = 1'b0;
`endif
      end
    end else begin
      commit_ok_s = 1'b0;
    end
    commit_err_s = commit_s && !commit_ok_s;
    err_s        = dig_err_s || commit_err_s;
  end

  // Entry FSM with registered entry digits, handshake request and error pulse.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_r      <= ST_IDLE;
      mins_r       <= 4'd0;
      tens_r       <= 4'd0;
      ones_r       <= 4'd0;
      count_r      <= 2'd0;
      preset_req_r <= 1'b0;
      entry_err_r  <= 1'b0;
    end else begin
      entry_err_r <= err_s;
      case (state_r)
        ST_IDLE, ST_ENTRY: begin
          if (bus.cancel) begin
            mins_r  <= 4'd0;
            tens_r  <= 4'd0;
            ones_r  <= 4'd0;
            count_r <= 2'd0;
            state_r <= ST_IDLE;
          end else begin
            mins_r  <= fin_mins_s;
            tens_r  <= fin_tens_s;
            ones_r  <= fin_ones_s;
            count_r <= sh_count_s;
            if (commit_ok_s) begin
              state_r      <= ST_REQ;
              preset_req_r <= 1'b1;
            end else if (has_entry_s) begin
              state_r <= ST_ENTRY;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_REQ: begin
          if (bus.preset_ack) begin
            mins_r       <= 4'd0;
            tens_r       <= 4'd0;
            ones_r       <= 4'd0;
            count_r      <= 2'd0;
            preset_req_r <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            state_r <= ST_REQ;
          end
        end
        default: begin
          mins_r       <= 4'd0;
          tens_r       <= 4'd0;
          ones_r       <= 4'd0;
          count_r      <= 2'd0;
          preset_req_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.entry_mins     = mins_r;
  assign bus.entry_sec_tens = tens_r;
  assign bus.entry_sec_ones = ones_r;
  assign bus.digit_count    = count_r;
  assign bus.preset_req     = preset_req_r;
  assign bus.entry_err      = entry_err_r;

endmodule

// File: tb/tb_keypad_entry_receiver.sv
// Scoreboard bench for keypad_entry_receiver: a digit-level model predicts each
// visible output change (and its clock cycle); a monitor checks them in order.
module tb_keypad_entry_receiver;
  localparam int SS  = 2;
  localparam int MAX = 5;

  typedef struct {
    int          cyc;
    logic [14:0] val;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic clearn = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  int mm = 0, mt = 0, mo = 0, mc = 0;
  bit mr = 1'b0;

  keypad_entry_receiver_if bus ();

  keypad_entry_receiver #(.SYNC_STAGES(SS), .MAX_SEC_TENS(4'd5)) dut (
    .clock  (clk),
    .clearn (clearn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] dut_val();
    return {bus.entry_mins, bus.entry_sec_tens, bus.entry_sec_ones, bus.digit_count, bus.preset_req};
  endfunction

  // Monitor: any visible change or error pulse must match the next prediction.
  logic [14:0] prev_val = 15'd0;
  always @(negedge clk) begin
    logic [14:0] cur;
    exp_t e;
    cur = dut_val();
    if (mon_en && ((cur !== prev_val) || (bus.entry_err !== 1'b0))) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output cyc=%0d actual val=%h err=%b, required no change", cyc, cur, bus.entry_err);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc != cyc) || (e.val !== cur) || (e.err !== bus.entry_err)) begin
          n_bad++;
          $display("FAIL output_event actual cyc=%0d val=%h err=%b, required cyc=%0d val=%h err=%b",
                   cyc, cur, bus.entry_err, e.cyc, e.val, e.err);
        end
      end
    end
    prev_val = cur;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mm = 0; mt = 0; mo = 0; mc = 0;
  endtask

  // Reference: effect of one clock's worth of events on the digit entry.
  task automatic model_step(input bit key, input int d, input bit mag, input bit cmt,
                            input bit cnc, input bit ack, input int at);
    int om, ot, oo, oc, s;
    bit orq, err;
    exp_t e;
    om = mm; ot = mt; oo = mo; oc = mc; orq = mr; err = 1'b0;
    if (mr) begin
      if (ack) begin
        model_clear();
        mr = 1'b0;
      end
    end else if (cnc) begin
      model_clear();
    end else begin
      if (key && !mag) begin
        if (d > 9 || mc == 3) err = 1'b1;
        else begin
          mm = mt; mt = mo; mo = d; mc++;
        end
      end
      if (cmt) begin
        if (mc == 0) err = 1'b1;
        else if (mt <= MAX) mr = 1'b1;
        else begin
`ifdef AUTO_NORMALIZE_EN
          s = 10 * mt + mo - 60;
          if (s >= 0 && mm < 9) begin
            mm++; mt = s / 10; mo = s % 10; mr = 1'b1;
          end else err = 1'b1;
`else
          s = 0;
          err = 1'b1;
`endif
        end
      end
    end
    if (err || om != mm || ot != mt || oo != mo || oc != mc || orq != mr) begin
      e.cyc = at;
      e.val = {4'(mm), 4'(mt), 4'(mo), 2'(mc), mr};
      e.err = err;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_key(input int d, input bit mag, input bit cmt, input bit cnc);
    int k;
    tick(1);
    k = cyc;
    bus.D = 4'(d);
    bus.mag_on = mag;
    bus.loadn = 1'b0;
    model_step(1'b1, d, mag, cmt, cnc, 1'b0, k + SS + 1);
    tick(SS);
    bus.commit = cmt;
    bus.cancel = cnc;
    tick(1);
    bus.commit = 1'b0;
    bus.cancel = 1'b0;
    bus.loadn = 1'b1;
    tick(4);
    bus.mag_on = 1'b0;
  endtask

  task automatic do_pulse(input bit cmt, input bit cnc, input bit ack);
    tick(1);
    bus.commit = cmt;
    bus.cancel = cnc;
    bus.preset_ack = ack;
    model_step(1'b0, 0, 1'b0, cmt, cnc, ack, cyc + 1);
    tick(1);
    bus.commit = 1'b0;
    bus.cancel = 1'b0;
    bus.preset_ack = 1'b0;
    tick(1);
  endtask

  task automatic reset_mid_cycle();
    exp_t e;
    tick(1);
    #1;
    clearn = 1'b0;
    model_clear();
    mr = 1'b0;
    e.cyc = cyc;
    e.val = 15'd0;
    e.err = 1'b0;
    exp_q.push_back(e);
    #1;
    check("rst_preset_req", int'(bus.preset_req), 0);
    check("rst_digits", int'({bus.entry_mins, bus.entry_sec_tens, bus.entry_sec_ones}), 0);
    check("rst_count", int'(bus.digit_count), 0);
    tick(1);
    clearn = 1'b1;
    tick(2);
  endtask

  initial begin
    int r;
    bus.D = 4'd0; bus.loadn = 1'b1; bus.mag_on = 1'b0;
    bus.commit = 1'b0; bus.cancel = 1'b0; bus.preset_ack = 1'b0;
    tick(3);
    clearn = 1'b1;
    tick(2);
    check("reset_outputs", int'(dut_val()), 0);
    check("reset_err", int'(bus.entry_err), 0);
    mon_en = 1'b1;

    do_key(1, 0, 0, 0); do_key(3, 0, 0, 0); do_key(0, 0, 0, 0);
    check("entry_130", int'({bus.entry_mins, bus.entry_sec_tens, bus.entry_sec_ones}), 'h130);
    do_pulse(1, 0, 0);
    do_key(7, 0, 0, 0);
    do_pulse(0, 1, 0);
    do_pulse(0, 0, 1);
    do_key(7, 0, 0, 0); do_key(5, 0, 0, 0);
    do_pulse(1, 0, 0);
    do_pulse(0, 0, 1);
    do_pulse(0, 1, 0);
    do_key(9, 0, 0, 0); do_key(7, 0, 0, 0); do_key(5, 0, 0, 0);
    do_pulse(1, 0, 0);
    do_pulse(0, 1, 0);
    do_key(2, 0, 0, 0); do_key(4, 0, 0, 0); do_key(5, 0, 0, 0);
    do_key(4, 0, 0, 0);
    do_key(12, 0, 0, 0);
    do_key(8, 1, 0, 0);
    do_pulse(1, 1, 0);
    do_pulse(1, 0, 0);
    do_key(3, 0, 0, 0); do_key(12, 0, 0, 0);
    do_key(0, 0, 1, 0);
    do_pulse(0, 0, 1);
    do_key(4, 0, 0, 1);
    do_key(1, 0, 0, 0); do_key(3, 0, 0, 0);
    do_pulse(1, 0, 0);
    reset_mid_cycle();
    do_pulse(1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 4)       do_key($urandom_range(0, 11), ($urandom_range(0, 7) == 0), 0, 0);
      else if (r <= 6)  do_pulse(1, 0, 0);
      else if (r == 7)  do_pulse(0, 1, 0);
      else if (r <= 9)  do_pulse(0, 0, 1);
      else if (r == 10) do_key($urandom_range(0, 10), 0, 1, 0);
      else if ($urandom_range(0, 1) == 0) do_pulse(1, 1, 0);
      else              do_key($urandom_range(0, 9), 0, 0, 1);
    end
    do_pulse(0, 0, 1);
    tick(5);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_entry_receiver.md
Name: keypad_entry_receiver

Overview:
- Receiving end of the keypad encoder's digit interface (D + loadn strobe).
- Synchronizes and edge-detects each strobe, then shifts accepted digits into a 3-digit BCD entry register (mins : sec_tens : sec_ones), microwave style: the newest key lands in sec_ones.
- On a commit request it validates the entry and hands it to the timer preset path with a req/ack handshake.
- Sits between encoder and timer; the display can show the entry while the block is idle.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on loadn and D (minimum 2).
- MAX_SEC_TENS, 5, largest legal sec_tens digit at commit.

Ports:
- clock  in  1  system clock; the only clock.
- clearn  in  1  asynchronous active-low reset.
- D  in  4  BCD digit from encoder; stable while loadn is low.
- loadn  in  1  active-low digit strobe from encoder; asynchronous to clock, at least 2 clock periods low.
- mag_on  in  1  magnetron running; key entry is locked while high.
- commit  in  1  single-cycle pulse requesting that the entry be preset into the timer.
- cancel  in  1  single-cycle pulse clearing the entry.
- preset_ack  in  1  timer accepted the preset.
- entry_mins  out  4  BCD minutes digit.
- entry_sec_tens  out  4  BCD tens-of-seconds digit.
- entry_sec_ones  out  4  BCD ones-of-seconds digit.
- digit_count  out  2  digits entered, 0..3.
- preset_req  out  1  preset pending; entry outputs are frozen while high.
- entry_err  out  1  one-cycle error pulse.

Behaviour:
- Reset (clearn low, async): all entry digits 0, digit_count 0, preset_req 0, entry_err 0, FSM in IDLE, synchronizers cleared to loadn=1.
- Strobe detect:
  - loadn passes through SYNC_STAGES flops; a falling edge (previous synced 1, current synced 0) is one strobe.
  - D is sampled from its own synchronizer on the strobe cycle.
  - Entry registers update on the cycle after the edge is detected, giving latency SYNC_STAGES+1 clocks from loadn falling.
- Digit acceptance: a strobe is accepted only in IDLE or ENTRY, with mag_on=0 and D<=9.
  - Accepted digit: entry_mins<=entry_sec_tens, entry_sec_tens<=entry_sec_ones, entry_sec_ones<=D, digit_count increments.
  - D>9: ignored, entry_err pulses.
  - digit_count==3: ignored, entry_err pulses; no shift-out of entry_mins.
  - mag_on=1: ignored silently, no error.
- FSM:
  - IDLE (count 0): accepted digit -> ENTRY; commit -> entry_err pulse, stay.
  - ENTRY: cancel -> clear entry, IDLE.
  - ENTRY, commit with entry_sec_tens<=MAX_SEC_TENS -> REQ.
  - ENTRY, commit with entry_sec_tens>MAX_SEC_TENS -> entry_err pulse, stay in ENTRY with the entry unchanged.
  - REQ: preset_req=1; entry outputs and digit_count held; strobes and cancel ignored.
  - REQ, preset_ack -> next cycle preset_req=0, entry cleared, IDLE.
- Simultaneous events:
  - cancel and commit in the same cycle: cancel wins.
  - Strobe and commit in the same cycle: the digit is shifted first and commit is evaluated on the post-shift value.
  - Strobe and cancel in the same cycle: cleared; the digit is discarded.
- preset_ack outside REQ is ignored.
- Reset during REQ: preset_req drops asynchronously; no handshake completes.

Optional Feature:
- Macro AUTO_NORMALIZE_EN.
- Defined: a commit with sec_tens>MAX_SEC_TENS normalizes instead of erroring.
  - Seconds field S=10*sec_tens+sec_ones is reduced by 60 and mins is incremented, both in BCD, over one cycle; then the FSM enters REQ.
  - If mins would exceed 9: entry_err pulses, stay in ENTRY unchanged.
  - Example: 0:90 -> 1:30.
- Undefined: a commit with sec_tens>MAX_SEC_TENS gives the entry_err pulse as described in Behaviour.

Test Plan:
- Reset, then strobes D=1,3,0 -> mins=1, sec_tens=3, sec_ones=0, count=3, each update exactly 3 clocks after loadn falls (SYNC_STAGES=2).
- Entry 1:30, commit, ack held off 5 cycles -> preset_req high 5 cycles with outputs frozen, a strobe D=7 meanwhile ignored; ack -> IDLE, digits 0.
- Entry 0:75, commit -> entry_err one pulse, stays ENTRY. With AUTO_NORMALIZE_EN: preset_req with 1:15. Entry 9:75 with AUTO_NORMALIZE_EN -> entry_err.
- Fourth digit D=4 after 2:45 -> entry_err, entry still 2:45. D=4'hC strobe -> entry_err, no shift. mag_on=1 strobe -> no change, no error.
- commit and cancel in the same cycle from ENTRY -> IDLE, digits 0, preset_req 0. Commit in IDLE -> entry_err.
- clearn asserted mid-REQ between clock edges -> preset_req and digits 0 immediately, FSM IDLE after release.
